// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported instruction/data memory between the IF and MEM
// stages. Data accesses normally win over fetches, but once STARVE_LIMIT data
// grants have been made in a row while a fetch was waiting, the fetch is
// forced ahead. Arbitration happens in IDLE and on every completion cycle, so
// back-to-back transactions need no idle bubble.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rstN,
  // IF stage port
  input  logic              fetchReq,
  input  logic [ADDR_W-1:0] fetchAddr,
  output logic              fetchDone,
  output logic [DATA_W-1:0] fetchRdata,
  // MEM stage port
  input  logic              dataReq,
  input  logic              dataWe,
  input  logic [ADDR_W-1:0] dataAddr,
  input  logic [DATA_W-1:0] dataWdata,
  output logic              dataDone,
  output logic [DATA_W-1:0] dataRdata,
  // Memory side
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata,
  input  logic              memReady,
  // Hazard unit
  output logic              stallFetch,
  output logic              stallData
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  state_t              r_state;
  logic [3:0]          r_streak;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic                w_arb;
  logic                w_starved;
  logic                w_grant_fetch;
  logic                w_grant_data;
  logic                w_fetch_done;
  logic                w_data_done;

  // Open an arbitration slot (idle, or the outstanding access completes) and pick the winner.
  always_comb begin
    w_arb         = 1'b0;
    w_starved     = 1'b0;
    w_grant_fetch = 1'b0;
    w_grant_data  = 1'b0;
    case (r_state)
      ST_IDLE:  w_arb = 1'b1;
      ST_FETCH: w_arb = memReady;
      ST_DATA:  w_arb = memReady;
      default:  w_arb = 1'b1;
    endcase
    w_starved = fetchReq && (r_streak == LP_LIMIT);
    if (w_arb) begin
      if (w_starved) begin
        w_grant_fetch = 1'b1;
      end else if (dataReq) begin
        w_grant_data = 1'b1;
      end else if (fetchReq) begin
        w_grant_fetch = 1'b1;
      end else begin
        w_grant_fetch = 1'b0;
        w_grant_data  = 1'b0;
      end
    end else begin
      w_grant_fetch = 1'b0;
      w_grant_data  = 1'b0;
    end
  end

  // Completion strobes: the outstanding access finishes in the cycle memReady is seen.
  always_comb begin
    w_fetch_done = (r_state == ST_FETCH) && memReady;
    w_data_done  = (r_state == ST_DATA) && memReady;
  end

  // Transaction FSM: latch the granted request into the memory-side registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state     <= ST_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= {DATA_W{1'b0}};
    end else begin
      if (w_grant_data) begin
        r_state     <= ST_DATA;
        r_mem_req   <= 1'b1;
        r_mem_we    <= dataWe;
        r_mem_addr  <= dataAddr;
        r_mem_wdata <= dataWdata;
      end else if (w_grant_fetch) begin
        r_state     <= ST_FETCH;
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= fetchAddr;
      end else if (w_arb) begin
        r_state     <= ST_IDLE;
        r_mem_req   <= 1'b0;
        r_mem_we    <= 1'b0;
      end else begin
        r_state     <= r_state;
      end
    end
  end

  // Starvation streak: data grants in a row while a fetch is waiting, saturating at the limit.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_streak <= 4'd0;
    end else if (!fetchReq || w_grant_fetch) begin
      r_streak <= 4'd0;
    end else if (w_grant_data && (r_streak < LP_LIMIT)) begin
      r_streak <= r_streak + 4'd1;
    end else begin
      r_streak <= r_streak;
    end
  end

  assign fetchDone  = w_fetch_done;
  assign dataDone   = w_data_done;
  assign fetchRdata = memRdata;
  assign dataRdata  = memRdata;
  assign memReq     = r_mem_req;
  assign memWe      = r_mem_we;
  assign memAddr    = r_mem_addr;
  assign memWdata   = r_mem_wdata;
  assign stallFetch = fetchReq & ~w_fetch_done;
  assign stallData  = dataReq & ~w_data_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a hand-derived vector table,
// directed multi-cycle sequences and a randomized run, all compared against a
// transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int STARVE = 4;

  logic          clk = 1'b0;
  logic          rstN;
  logic          fetchReq, dataReq, dataWe, memReady;
  logic [AW-1:0] fetchAddr, dataAddr, memAddr;
  logic [DW-1:0] dataWdata, memRdata, fetchRdata, dataRdata, memWdata;
  logic          fetchDone, dataDone, memReq, memWe, stallFetch, stallData;

  int n_pass  = 0;
  int n_total = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rstN(rstN),
    .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchDone(fetchDone), .fetchRdata(fetchRdata),
    .dataReq(dataReq), .dataWe(dataWe), .dataAddr(dataAddr), .dataWdata(dataWdata),
    .dataDone(dataDone), .dataRdata(dataRdata),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata), .memReady(memReady),
    .stallFetch(stallFetch), .stallData(stallData)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    logic          is_data;
    logic          we;
    logic [AW-1:0] addr;
  } txn_t;

  txn_t          pend[$];       // the transaction currently owned by memory (0 or 1 entries)
  logic [AW-1:0] m_addr;        // address of the most recent grant
  logic [DW-1:0] m_wdata;       // write data of the most recent data grant
  int            m_run;         // data grants in a row that a waiting fetch has watched
  logic          e_fd, e_dd, e_dl, e_sf, e_sd;

  // sampled combinational outputs of the latest step
  logic          s_fd, s_dd, s_sf, s_sd;
  logic [DW-1:0] s_frd, s_drd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    pend.delete();
    m_addr  = '0;
    m_wdata = '0;
    m_run   = 0;
  endtask

  task automatic model_expect();
    e_fd = 1'b0; e_dd = 1'b0; e_dl = 1'b0;
    if (pend.size() != 0 && memReady === 1'b1) begin
      if (pend[0].is_data) begin
        e_dd = 1'b1;
        e_dl = !pend[0].we;
      end else begin
        e_fd = 1'b1;
      end
    end
    e_sf = fetchReq && !e_fd;
    e_sd = dataReq && !e_dd;
  endtask

  task automatic model_advance();
    bit   slot, starved, granted_fetch, granted_data;
    txn_t t;
    granted_fetch = 1'b0;
    granted_data  = 1'b0;
    slot = (pend.size() == 0) || (memReady === 1'b1);
    if (slot) begin
      pend.delete();
      starved = fetchReq && (m_run >= STARVE);
      if (dataReq && !starved) begin
        t.is_data = 1'b1; t.we = dataWe; t.addr = dataAddr;
        pend.push_back(t);
        m_addr  = dataAddr;
        m_wdata = dataWdata;
        granted_data = 1'b1;
      end else if (fetchReq) begin
        t.is_data = 1'b0; t.we = 1'b0; t.addr = fetchAddr;
        pend.push_back(t);
        m_addr = fetchAddr;
        granted_fetch = 1'b1;
      end
    end
    if (!fetchReq || granted_fetch) m_run = 0;
    else if (granted_data && m_run < STARVE) m_run++;
  endtask

  // One clock: drive inputs after the falling edge, check combinational
  // outputs, then check registered outputs just after the rising edge.
  task automatic step(input logic fr, input logic [AW-1:0] fa, input logic dr, input logic we,
                      input logic [AW-1:0] da, input logic [DW-1:0] wd, input logic rdy,
                      input logic [DW-1:0] rd);
    @(negedge clk);
    fetchReq = fr; fetchAddr = fa; dataReq = dr; dataWe = we;
    dataAddr = da; dataWdata = wd; memReady = rdy; memRdata = rd;
    #1;
    s_fd = fetchDone; s_dd = dataDone; s_sf = stallFetch; s_sd = stallData;
    s_frd = fetchRdata; s_drd = dataRdata;
    model_expect();
    chk("fetchDone", s_fd, e_fd);
    chk("dataDone", s_dd, e_dd);
    chk("stallFetch", s_sf, e_sf);
    chk("stallData", s_sd, e_sd);
    if (e_fd) chk("fetchRdata", s_frd, rd);
    if (e_dl) chk("dataRdata", s_drd, rd);
    model_advance();
    @(posedge clk);
    #1;
    chk("memReq", memReq, (pend.size() != 0));
    chk("memWe", memWe, (pend.size() != 0) ? pend[0].we : 1'b0);
    chk("memAddr", memAddr, m_addr);
    chk("memWdata", memWdata, m_wdata);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          fr;
    logic [AW-1:0] fa;
    logic          dr;
    logic          we;
    logic [AW-1:0] da;
    logic [DW-1:0] wd;
    logic          rdy;
    logic [DW-1:0] rd;
    logic          fd, dd, sf, sd, mreq, mwe;
    logic [AW-1:0] maddr;
  } vec_t;

  function automatic vec_t mkv(logic fr, logic [AW-1:0] fa, logic dr, logic we, logic [AW-1:0] da,
                               logic [DW-1:0] wd, logic rdy, logic [DW-1:0] rd, logic fd, logic dd,
                               logic sf, logic sd, logic mreq, logic mwe, logic [AW-1:0] maddr);
    vec_t v;
    v.fr = fr; v.fa = fa; v.dr = dr; v.we = we; v.da = da; v.wd = wd; v.rdy = rdy; v.rd = rd;
    v.fd = fd; v.dd = dd; v.sf = sf; v.sd = sd; v.mreq = mreq; v.mwe = mwe; v.maddr = maddr;
    return v;
  endfunction

  vec_t          vecs[13];
  logic [AW-1:0] st_da[6];
  logic [AW-1:0] st_exp[6];
  int            n_dd, n_fd;

  initial begin
    // conflict: store to 0x40 wins, fetch 0x200 follows right after dataDone
    vecs[0]  = mkv(1'b1, 32'h200, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
    vecs[1]  = mkv(1'b1, 32'h200, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
    vecs[2]  = mkv(1'b1, 32'h200, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b1, 32'h0,
                   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200);
    // back-to-back with memReady high: fetch, fetch, data, fetch, then idle
    vecs[3]  = mkv(1'b1, 32'h204, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'h00500093,
                   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h204);
    vecs[4]  = mkv(1'b1, 32'h204, 1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 32'h11111111,
                   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80);
    vecs[5]  = mkv(1'b1, 32'h208, 1'b0, 1'b0, 32'h80, 32'h0, 1'b1, 32'h22222222,
                   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h208);
    vecs[6]  = mkv(1'b0, 32'h208, 1'b0, 1'b0, 32'h80, 32'h0, 1'b1, 32'h33333333,
                   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h208);
    vecs[7]  = mkv(1'b0, 32'h208, 1'b0, 1'b0, 32'h80, 32'h0, 1'b1, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h208);
    // single fetch of 0x100, memReady two cycles after memReq rises
    vecs[8]  = mkv(1'b1, 32'h100, 1'b0, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100);
    vecs[9]  = mkv(1'b1, 32'h100, 1'b0, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100);
    vecs[10] = mkv(1'b1, 32'h100, 1'b0, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100);
    vecs[11] = mkv(1'b0, 32'h100, 1'b0, 1'b0, 32'h80, 32'h0, 1'b1, 32'h00500093,
                   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100);
    vecs[12] = mkv(1'b0, 32'h100, 1'b0, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100);

    st_da[0] = 32'h1000; st_da[1] = 32'h1004; st_da[2] = 32'h1008;
    st_da[3] = 32'h100C; st_da[4] = 32'h1010; st_da[5] = 32'h1010;
    st_exp[0] = 32'h1000; st_exp[1] = 32'h1004; st_exp[2] = 32'h1008;
    st_exp[3] = 32'h100C; st_exp[4] = 32'h300;  st_exp[5] = 32'h1010;

    // ---- reset state, with requests and memReady active during reset ----
    rstN = 1'b1;
    fetchReq = 1'b1; fetchAddr = 32'h10; dataReq = 1'b1; dataWe = 1'b1;
    dataAddr = 32'h20; dataWdata = 32'h55; memReady = 1'b1; memRdata = 32'h0;
    #1 rstN = 1'b0;
    #12;
    chk("rst_memReq", memReq, 1'b0);
    chk("rst_memWe", memWe, 1'b0);
    chk("rst_memAddr", memAddr, 32'h0);
    chk("rst_memWdata", memWdata, 32'h0);
    chk("rst_fetchDone", fetchDone, 1'b0);
    chk("rst_dataDone", dataDone, 1'b0);
    @(negedge clk);
    fetchReq = 1'b0; dataReq = 1'b0; memReady = 1'b0;
    rstN = 1'b1;
    model_reset();

    // ---- table-driven vectors ----
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].fr, vecs[i].fa, vecs[i].dr, vecs[i].we, vecs[i].da, vecs[i].wd,
           vecs[i].rdy, vecs[i].rd);
      chk("vec_fetchDone", s_fd, vecs[i].fd);
      chk("vec_dataDone", s_dd, vecs[i].dd);
      chk("vec_stallFetch", s_sf, vecs[i].sf);
      chk("vec_stallData", s_sd, vecs[i].sd);
      chk("vec_memReq", memReq, vecs[i].mreq);
      chk("vec_memWe", memWe, vecs[i].mwe);
      chk("vec_memAddr", memAddr, vecs[i].maddr);
      if (vecs[i].fd) chk("vec_fetchRdata", s_frd, vecs[i].rd);
      if (vecs[i].dd && !vecs[i].we) chk("vec_dataRdata", s_drd, vecs[i].rd);
    end
    chk("vec_store_wdata_kept", memWdata, 32'h0);

    // ---- starvation: data and fetch both held, memReady tied high ----
    n_dd = 0; n_fd = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 32'h300, 1'b1, 1'b0, st_da[k], 32'h0, 1'b1, 32'hA0 + 32'(k));
      if (s_dd) n_dd++;
      if (s_fd) n_fd++;
      chk("starve_order", memAddr, st_exp[k]);
      chk("starve_memReq", memReq, 1'b1);
    end
    chk("starve_data_dones", 32'(n_dd), 32'd4);
    chk("starve_fetch_dones", 32'(n_fd), 32'd1);
    step(1'b0, 32'h300, 1'b0, 1'b0, 32'h1010, 32'h0, 1'b1, 32'hB0);
    chk("starve_resumed_done", s_dd, 1'b1);

    // ---- requester withdrawal: dataReq drops one cycle after grant ----
    n_dd = 0;
    step(1'b1, 32'h400, 1'b1, 1'b0, 32'h60, 32'h0, 1'b0, 32'h0);
    chk("wd_grant_addr", memAddr, 32'h60);
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 32'h400, 1'b0, 1'b0, 32'h60, 32'h0, 1'b0, 32'h0);
      if (s_dd) n_dd++;
      chk("wd_memReq_held", memReq, 1'b1);
      chk("wd_addr_held", memAddr, 32'h60);
    end
    step(1'b1, 32'h400, 1'b0, 1'b0, 32'h60, 32'h0, 1'b1, 32'h77);
    if (s_dd) n_dd++;
    chk("wd_next_is_fetch", memAddr, 32'h400);
    chk("wd_data_dones", 32'(n_dd), 32'd1);
    step(1'b0, 32'h400, 1'b0, 1'b0, 32'h60, 32'h0, 1'b1, 32'h88);
    chk("wd_fetch_done", s_fd, 1'b1);

    // ---- reset in the middle of a fetch ----
    step(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("mid_memReq_before", memReq, 1'b1);
    @(negedge clk);
    memReady = 1'b1;
    #2 rstN = 1'b0;
    #1;
    chk("mid_rst_memReq", memReq, 1'b0);
    chk("mid_rst_memWe", memWe, 1'b0);
    chk("mid_rst_memAddr", memAddr, 32'h0);
    chk("mid_rst_fetchDone", fetchDone, 1'b0);
    model_reset();
    @(negedge clk);
    fetchReq = 1'b0; dataReq = 1'b0;
    rstN = 1'b1;
    step(1'b0, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h99);
    chk("mid_after_idle_fd", s_fd, 1'b0);

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) != 0,
           $urandom_range(0, 1) != 0, $urandom, $urandom, $urandom_range(0, 2) != 0, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
